// File: rtl/regfile_mp_pkg.sv
// Shared register-file constants, also consumed by the cpu core.
// Architectural defaults; the regfile exposes them as overridable parameters.
package regfile_mp_pkg;

  localparam int RF_DAT_WIDTH = 64;
  localparam int RF_NUM_REGS  = 32;
  localparam int RF_REG_ZERO  = 0;
  localparam int RF_REG_PC    = RF_NUM_REGS - 1;
  localparam logic [RF_DAT_WIDTH-1:0] RF_PC_RESET = 64'h0000_8000_0000_0000;

  // PC advances by one machine word per increment
  function automatic int pc_step(input int dat_width);
    return dat_width / 8;
  endfunction

  localparam int RF_PC_STEP = pc_step(RF_DAT_WIDTH);

endpackage

// File: rtl/regfile_mp_if.sv
// Register-file access bundle: read ports, write port, pending-set and PC control.
interface regfile_mp_if #(
  parameter int NUM_RD    = 2,
  parameter int ID_W      = 5,
  parameter int DAT_WIDTH = 64
);
  logic [NUM_RD-1:0]           rd_en_i;
  logic [NUM_RD*ID_W-1:0]      rd_id_i;
  logic [NUM_RD*DAT_WIDTH-1:0] rd_dat_o;
  logic [NUM_RD-1:0]           rd_vld_o;
  logic [NUM_RD-1:0]           rd_pend_o;
  logic                        we_i;
  logic [ID_W-1:0]             wr_id_i;
  logic [DAT_WIDTH-1:0]        wr_dat_i;
  logic                        pend_set_i;
  logic [ID_W-1:0]             pend_id_i;
  logic                        pc_inc_i;
  logic [DAT_WIDTH-1:0]        pc_o;

  modport master (
    output rd_en_i, rd_id_i, we_i, wr_id_i, wr_dat_i, pend_set_i, pend_id_i, pc_inc_i,
    input  rd_dat_o, rd_vld_o, rd_pend_o, pc_o
  );

  modport slave (
    input  rd_en_i, rd_id_i, we_i, wr_id_i, wr_dat_i, pend_set_i, pend_id_i, pc_inc_i,
    output rd_dat_o, rd_vld_o, rd_pend_o, pc_o
  );
endinterface

// File: rtl/regfile_mp_rd_port.sv
// One registered read port: resolves zero/range, write-through and PC-increment
// bypass against the storage value and registers the result.
module regfile_mp_rd_port
  import regfile_mp_pkg::*;
#(
  parameter int DAT_WIDTH = RF_DAT_WIDTH,
  parameter int ID_W      = 5,
  parameter int REG_ZERO  = RF_REG_ZERO,
  parameter int REG_PC    = RF_REG_PC
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 en,
  input  logic [ID_W-1:0]      id,
  input  logic                 rng,
  input  logic [DAT_WIDTH-1:0] stor_dat,
  input  logic                 stor_pend,
  input  logic                 we,
  input  logic [ID_W-1:0]      wr_id,
  input  logic [DAT_WIDTH-1:0] wr_dat,
  input  logic                 pc_inc,
  input  logic [DAT_WIDTH-1:0] pc_inc_dat,
  output logic [DAT_WIDTH-1:0] dat,
  output logic                 vld,
  output logic                 pend
);

  logic [DAT_WIDTH-1:0] nxt_dat;
  logic                 nxt_pend;

  // A write in flight overrides a PC increment on the same register
  always_comb begin
    nxt_dat  = stor_dat;
    nxt_pend = stor_pend;
    if (!rng || id == ID_W'(REG_ZERO)) begin
      nxt_dat  = '0;
      nxt_pend = 1'b0;
    end else if (we && wr_id == id) begin
      nxt_dat  = wr_dat;
      nxt_pend = 1'b0;
    end else if (pc_inc && id == ID_W'(REG_PC)) begin
      nxt_dat  = pc_inc_dat;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      dat  <= '0;
      vld  <= 1'b0;
      pend <= 1'b0;
    end else begin
      vld <= en;
      if (en) begin
        dat  <= nxt_dat;
        pend <= nxt_pend;
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with scoreboard pending bits and a dedicated PC port.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DAT_WIDTH = RF_DAT_WIDTH,
  parameter int NUM_REGS  = RF_NUM_REGS,
  parameter int NUM_RD    = 2,
  parameter int REG_ZERO  = RF_REG_ZERO,
  parameter int REG_PC    = NUM_REGS - 1,
  parameter logic [DAT_WIDTH-1:0] PC_RESET = DAT_WIDTH'(RF_PC_RESET),
  parameter int ID_W      = $clog2(NUM_REGS)
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  regfile_mp_if.slave bus
);

  localparam logic [DAT_WIDTH-1:0] PC_STEP = DAT_WIDTH'(pc_step(DAT_WIDTH));

  logic [DAT_WIDTH-1:0]              regs [NUM_REGS];
  logic [NUM_REGS-1:0]               pend;
  logic [NUM_REGS-1:0]               wr_hit;
  logic [NUM_REGS-1:0]               set_hit;
  logic [DAT_WIDTH-1:0]              pc_inc_dat;
  logic [DAT_WIDTH-1:0]              pc_nxt;
  logic [NUM_RD-1:0][DAT_WIDTH-1:0]  rd_dat;
  logic [NUM_RD-1:0]                 rd_vld;
  logic [NUM_RD-1:0]                 rd_pend;

  // Out-of-range and zero-register targets never match, so they are dropped here
  always_comb begin
    wr_hit  = '0;
    set_hit = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (i != REG_ZERO) begin
        wr_hit[i]  = bus.we_i && (bus.wr_id_i == ID_W'(i));
        set_hit[i] = bus.pend_set_i && (bus.pend_id_i == ID_W'(i));
      end
    end
  end

  assign pc_inc_dat = regs[REG_PC] + PC_STEP;

  always_comb begin
    pc_nxt = regs[REG_PC];
    if (wr_hit[REG_PC])    pc_nxt = bus.wr_dat_i;
    else if (bus.pc_inc_i) pc_nxt = pc_inc_dat;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= (i == REG_PC) ? PC_RESET : '0;
      pend <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (i == REG_PC)    regs[i] <= pc_nxt;
        else if (wr_hit[i]) regs[i] <= bus.wr_dat_i;
        // set beats the write's clear when both hit the same register
        if (set_hit[i])     pend[i] <= 1'b1;
        else if (wr_hit[i]) pend[i] <= 1'b0;
      end
    end
  end

  assign bus.pc_o = regs[REG_PC];

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ID_W-1:0] id;
    logic            rng;
    assign id  = bus.rd_id_i[p*ID_W +: ID_W];
    assign rng = ({1'b0, id} < (ID_W+1)'(NUM_REGS));

    regfile_mp_rd_port #(
      .DAT_WIDTH (DAT_WIDTH),
      .ID_W      (ID_W),
      .REG_ZERO  (REG_ZERO),
      .REG_PC    (REG_PC)
    ) u_rd (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .en         (bus.rd_en_i[p]),
      .id         (id),
      .rng        (rng),
      .stor_dat   (regs[id]),
      .stor_pend  (pend[id]),
      .we         (bus.we_i),
      .wr_id      (bus.wr_id_i),
      .wr_dat     (bus.wr_dat_i),
      .pc_inc     (bus.pc_inc_i),
      .pc_inc_dat (pc_inc_dat),
      .dat        (rd_dat[p]),
      .vld        (rd_vld[p]),
      .pend       (rd_pend[p])
    );
  end

  assign bus.rd_dat_o  = rd_dat;
  assign bus.rd_vld_o  = rd_vld;
  assign bus.rd_pend_o = rd_pend;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed plus randomized bench for regfile_mp against an architectural model.
module tb_regfile_mp;

  localparam logic [63:0] PC_RST = 64'h0000_8000_0000_0000;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  regfile_mp_if #(.NUM_RD(2), .ID_W(5), .DAT_WIDTH(64)) bus ();

  regfile_mp #(.NUM_RD(2)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural state: register values and scoreboard bits
  logic [63:0] m_reg  [32];
  logic        m_pend [32];
  logic [63:0] exp_dat [2];
  logic [1:0]  exp_vld;
  logic [1:0]  exp_pend;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_reg[i]  = (i == 31) ? PC_RST : 64'd0;
      m_pend[i] = 1'b0;
    end
    exp_dat[0] = '0;
    exp_dat[1] = '0;
    exp_vld    = '0;
    exp_pend   = '0;
  endtask

  task automatic check_outs(input string tag);
    chk({tag, "_vld"},  64'(bus.rd_vld_o),  64'(exp_vld));
    chk({tag, "_pend"}, 64'(bus.rd_pend_o), 64'(exp_pend));
    chk({tag, "_dat0"}, bus.rd_dat_o[63:0],   exp_dat[0]);
    chk({tag, "_dat1"}, bus.rd_dat_o[127:64], exp_dat[1]);
    chk({tag, "_pc"},   bus.pc_o,             m_reg[31]);
  endtask

  task automatic drive(input logic [1:0] en, input int id0, input int id1,
                       input logic we, input int wid, input logic [63:0] wdat,
                       input logic ps, input int pid, input logic inc);
    bus.rd_en_i    = en;
    bus.rd_id_i    = {5'(id1), 5'(id0)};
    bus.we_i       = we;
    bus.wr_id_i    = 5'(wid);
    bus.wr_dat_i   = wdat;
    bus.pend_set_i = ps;
    bus.pend_id_i  = 5'(pid);
    bus.pc_inc_i   = inc;
  endtask

  task automatic idle();
    drive(2'b00, 0, 0, 1'b0, 0, 64'd0, 1'b0, 0, 1'b0);
  endtask

  // A read returns the register's value as it stands after this edge; its
  // pending flag is the pre-edge bit, cleared when this cycle writes it.
  task automatic cycle(input string tag);
    logic [63:0] nreg  [32];
    logic        npend [32];
    int          id;
    nreg  = m_reg;
    npend = m_pend;
    if (bus.pc_inc_i) nreg[31] = m_reg[31] + 64'd8;
    if (bus.we_i && bus.wr_id_i != 5'd0) begin
      nreg[bus.wr_id_i]  = bus.wr_dat_i;
      npend[bus.wr_id_i] = 1'b0;
    end
    if (bus.pend_set_i && bus.pend_id_i != 5'd0) npend[bus.pend_id_i] = 1'b1;
    exp_vld = bus.rd_en_i;
    for (int p = 0; p < 2; p++) begin
      if (bus.rd_en_i[p]) begin
        id          = int'(bus.rd_id_i[p*5 +: 5]);
        exp_dat[p]  = nreg[id];
        exp_pend[p] = (bus.we_i && int'(bus.wr_id_i) == id) ? 1'b0 : m_pend[id];
      end
    end
    @(posedge clk);
    #1;
    m_reg  = nreg;
    m_pend = npend;
    check_outs(tag);
  endtask

  function automatic int pick_id();
    int hot [4];
    hot = '{0, 5, 7, 31};
    if ($urandom_range(0, 2) == 0) return hot[$urandom_range(0, 3)];
    return int'($urandom_range(0, 31));
  endfunction

  initial begin
    logic [63:0] wd;
    rst_n = 1'b0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outs("rst");
    rst_n = 1'b1;

    // reset PC and zero register on both ports
    drive(2'b11, 31, 0, 1'b0, 0, 64'd0, 1'b0, 0, 1'b0);
    chk("t1_pc_now", bus.pc_o, PC_RST);
    cycle("t1");
    chk("t1_dat0", bus.rd_dat_o[63:0], PC_RST);
    chk("t1_dat1", bus.rd_dat_o[127:64], 64'd0);
    chk("t1_vld", 64'(bus.rd_vld_o), 64'd3);

    // write-through bypass then plain read
    drive(2'b01, 5, 0, 1'b1, 5, 64'h1234, 1'b0, 0, 1'b0);
    cycle("t2a");
    chk("t2_byp", bus.rd_dat_o[63:0], 64'h1234);
    drive(2'b01, 5, 0, 1'b0, 0, 64'd0, 1'b0, 0, 1'b0);
    cycle("t2b");
    chk("t2_rd", bus.rd_dat_o[63:0], 64'h1234);

    // PC increments, write priority, and wrap
    drive(2'b00, 0, 0, 1'b0, 0, 64'd0, 1'b0, 0, 1'b1);
    repeat (3) cycle("t3i");
    chk("t3_pc3", bus.pc_o, 64'h0000_8000_0000_0018);
    drive(2'b10, 0, 31, 1'b1, 31, 64'h40, 1'b0, 0, 1'b1);
    cycle("t3w");
    chk("t3_pcw", bus.pc_o, 64'h40);
    chk("t3_byp", bus.rd_dat_o[127:64], 64'h40);
    drive(2'b00, 0, 0, 1'b1, 31, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 0, 1'b0);
    cycle("t3m");
    drive(2'b01, 31, 0, 1'b0, 0, 64'd0, 1'b0, 0, 1'b1);
    cycle("t3z");
    chk("t3_wrap", bus.pc_o, 64'd0);
    chk("t3_incbyp", bus.rd_dat_o[63:0], 64'd0);

    // zero register ignores writes and pend_set
    drive(2'b00, 0, 0, 1'b1, 0, 64'hFFFF, 1'b0, 0, 1'b0);
    cycle("t4w");
    drive(2'b01, 0, 0, 1'b0, 0, 64'd0, 1'b1, 0, 1'b0);
    cycle("t4r");
    chk("t4_r0", bus.rd_dat_o[63:0], 64'd0);
    drive(2'b01, 0, 0, 1'b0, 0, 64'd0, 1'b0, 0, 1'b0);
    cycle("t4p");
    chk("t4_pend", 64'(bus.rd_pend_o), 64'd0);

    // scoreboard set / clear / set-wins
    drive(2'b00, 0, 0, 1'b0, 0, 64'd0, 1'b1, 7, 1'b0);
    cycle("t5s");
    drive(2'b01, 7, 0, 1'b0, 0, 64'd0, 1'b0, 0, 1'b0);
    cycle("t5r");
    chk("t5_pend1", 64'(bus.rd_pend_o[0]), 64'd1);
    drive(2'b00, 0, 0, 1'b1, 7, 64'hAB, 1'b0, 0, 1'b0);
    cycle("t5w");
    drive(2'b01, 7, 0, 1'b0, 0, 64'd0, 1'b0, 0, 1'b0);
    cycle("t5c");
    chk("t5_dat", bus.rd_dat_o[63:0], 64'hAB);
    chk("t5_clr", 64'(bus.rd_pend_o[0]), 64'd0);
    drive(2'b00, 0, 0, 1'b1, 7, 64'hAB, 1'b1, 7, 1'b0);
    cycle("t5b");
    drive(2'b01, 7, 0, 1'b0, 0, 64'd0, 1'b0, 0, 1'b0);
    cycle("t5d");
    chk("t5_dat2", bus.rd_dat_o[63:0], 64'hAB);
    chk("t5_win", 64'(bus.rd_pend_o[0]), 64'd1);

    // asynchronous reset between edges
    drive(2'b11, 7, 31, 1'b0, 0, 64'd0, 1'b0, 0, 1'b1);
    cycle("t6a");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6_vld", 64'(bus.rd_vld_o), 64'd0);
    chk("t6_pend", 64'(bus.rd_pend_o), 64'd0);
    chk("t6_dat0", bus.rd_dat_o[63:0], 64'd0);
    chk("t6_dat1", bus.rd_dat_o[127:64], 64'd0);
    chk("t6_pc", bus.pc_o, PC_RST);
    idle();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(2'b01, 7, 0, 1'b0, 0, 64'd0, 1'b0, 0, 1'b0);
    cycle("t6r");
    chk("t6_nopend", 64'(bus.rd_pend_o[0]), 64'd0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      wd = {$urandom, $urandom};
      if ($urandom_range(0, 15) == 0) wd = 64'hFFFF_FFFF_FFFF_FFF0;
      drive(2'($urandom_range(0, 3)), pick_id(), pick_id(),
            1'($urandom_range(0, 1)), pick_id(), wd,
            1'($urandom_range(0, 9) < 3), pick_id(),
            1'($urandom_range(0, 9) < 3));
      cycle("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
